// File: rtl/finite_log_search.sv
// finite_log_search: serial discrete logarithm over GF(2^M).
// Given a nonzero standard-basis operand x, finds k with alpha^k == x by
// stepping an alpha-power accumulator one exponent per clock.
// Operand and result each use a valid/ready handshake.
// Optional build macro: BCH_LOG_BIDIR_SEARCH_EN adds a second accumulator.
// It walks down from alpha^-1, so the search meets in the middle and
// worst-case latency is roughly halved.
module finite_log_search #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] standard_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] log_out,
    output logic         zero_err
);

    // Low-order bits of a primitive polynomial per field degree (x^M implicit),
    // matching the BCH_POLYNOMIAL choices used elsewhere in the BCH datapath.
    function automatic logic [15:0] primitive_poly(input int m);
        case (m)
            2:       return 16'h0003;
            3:       return 16'h0003;
            4:       return 16'h0003;
            5:       return 16'h0005;
            6:       return 16'h0003;
            7:       return 16'h0003;
            8:       return 16'h001D;
            9:       return 16'h0011;
            10:      return 16'h0009;
            11:      return 16'h0005;
            12:      return 16'h0053;
            13:      return 16'h001B;
            14:      return 16'h0443;
            15:      return 16'h0003;
            16:      return 16'h100B;
            default: return 16'h0003;
        endcase
    endfunction

    localparam logic [15:0]  POLY_FULL = primitive_poly(M);
    localparam logic [M-1:0] POLY      = POLY_FULL[M-1:0];
    localparam logic [M-1:0] ZERO      = {M{1'b0}};
    localparam logic [M-1:0] ONE       = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] ALL_ONES  = {M{1'b1}};

    // Multiply a field element by alpha.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (POLY & {M{v[M-1]}});
    endfunction

`ifdef BCH_LOG_BIDIR_SEARCH_EN
    localparam logic [M-1:0] TOP_BIT   = {1'b1, {(M-1){1'b0}}};
    // alpha^-1 = (POLY >> 1) | x^(M-1), valid because POLY[0] is set
    localparam logic [M-1:0] ALPHA_INV = (POLY >> 1) | TOP_BIT;
    localparam logic [M-1:0] K_TOP     = ALL_ONES - ONE;

    // Multiply a field element by alpha^-1.
    function automatic logic [M-1:0] div_alpha(input logic [M-1:0] v);
        return v[0] ? (((v ^ POLY) >> 1) | TOP_BIT) : (v >> 1);
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_r;
    logic [M-1:0]   target_r;
    logic [M-1:0]   fwd_r;
    logic [M-1:0]   kf_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [M-1:0]   log_out_r;
    logic           zero_err_r;

    logic [M-1:0]   fwd_step_s;
    logic           fwd_hit_s;
    logic           guard_s;

`ifdef BCH_LOG_BIDIR_SEARCH_EN
    logic [M-1:0]   bwd_r;
    logic [M-1:0]   kb_r;
    logic [M-1:0]   bwd_step_s;
    logic           bwd_hit_s;
`endif

    // Next accumulator values, match detection and exhaustion guard.
    always_comb begin
        fwd_step_s = mul_alpha(fwd_r);
        fwd_hit_s  = (fwd_r == target_r);
`ifdef BCH_LOG_BIDIR_SEARCH_EN
        bwd_step_s = div_alpha(bwd_r);
        bwd_hit_s  = (bwd_r == target_r);
        // Both walks have crossed without a hit
        guard_s    = (kf_r > kb_r);
`else
        // Every exponent 0 .. 2^M-2 was tried without a hit
        guard_s    = (kf_r == ALL_ONES);
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            target_r    <= ZERO;
            fwd_r       <= ZERO;
            kf_r        <= ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            log_out_r   <= ZERO;
            zero_err_r  <= 1'b0;
`ifdef BCH_LOG_BIDIR_SEARCH_EN
            bwd_r       <= ZERO;
            kb_r        <= ZERO;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        target_r   <= standard_in;
                        fwd_r      <= ONE;
                        kf_r       <= ZERO;
`ifdef BCH_LOG_BIDIR_SEARCH_EN
                        bwd_r      <= ALPHA_INV;
                        kb_r       <= K_TOP;
`endif
                        in_ready_r <= 1'b0;
                        state_r    <= SEARCH;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (target_r == ZERO) begin
                        // log(0) is undefined
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        log_out_r   <= ZERO;
                        zero_err_r  <= 1'b1;
                    end else if (fwd_hit_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        log_out_r   <= kf_r;
                        zero_err_r  <= 1'b0;
`ifdef BCH_LOG_BIDIR_SEARCH_EN
                    end else if (bwd_hit_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        log_out_r   <= kb_r;
                        zero_err_r  <= 1'b0;
`endif
                    end else if (guard_s) begin
                        // Only reachable with a non-primitive polynomial
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        log_out_r   <= ZERO;
                        zero_err_r  <= 1'b1;
                    end else begin
                        fwd_r <= fwd_step_s;
                        kf_r  <= kf_r + ONE;
`ifdef BCH_LOG_BIDIR_SEARCH_EN
                        bwd_r <= bwd_step_s;
                        kb_r  <= kb_r - ONE;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        log_out_r   <= ZERO;
                        zero_err_r  <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    log_out_r   <= ZERO;
                    zero_err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign log_out   = log_out_r;
    assign zero_err  = zero_err_r;

endmodule

// File: tb/tb_finite_log_search.sv
// Testbench for finite_log_search (M=4, x^4+x+1).
// Expected logs and latencies come from a power table built by integer
// polynomial arithmetic; a scoreboard queue decouples driver and monitor.
module tb_finite_log_search;

    localparam int M    = 4;
    localparam int NEL  = 1 << M;      // field size
    localparam int ORD  = NEL - 1;     // multiplicative group order
    localparam int PFUL = 'h13;        // x^4 + x + 1, with the x^4 term

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] standard_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [M-1:0] log_out;
    logic         zero_err;

    finite_log_search #(.M(M)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .standard_in (standard_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .log_out     (log_out),
        .zero_err    (zero_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int log;
        int err;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   log_tab[NEL];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // log table: walk alpha^k as integer polynomials reduced mod PFUL
    task automatic build_model();
        int p;
        p = 1;
        for (int k = 0; k < ORD; k++) begin
            log_tab[p] = k;
            p = p << 1;
            if (p >= NEL) p = p ^ PFUL;
        end
    endtask

    function automatic exp_t model(input int x);
        exp_t e;
        e.acc = 0;
        if (x == 0) begin
            e.log = 0; e.err = 1; e.lat = 1;
        end else begin
            e.log = log_tab[x]; e.err = 0;
`ifdef BCH_LOG_BIDIR_SEARCH_EN
            // forward walk reaches k after k steps, backward after (ORD-1-k)
            e.lat = ((e.log < (ORD - 1 - e.log)) ? e.log : (ORD - 1 - e.log)) + 1;
`else
            e.lat = e.log + 1;
`endif
        end
        return e;
    endfunction

    // random consumer back-pressure, forced low while hold_ready is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: compares results on first appearance, then checks they hold
    bit   seen = 1'b0;
    int   seen_log = 0;
    int   seen_err = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                if (!seen) begin
                    seen     = 1'b1;
                    seen_log = int'(log_out);
                    seen_err = int'(zero_err);
                    check("log_out", int'(log_out), sb[0].log);
                    check("zero_err", int'(zero_err), sb[0].err);
                    check("latency", cyc - sb[0].acc, sb[0].lat);
                end else begin
                    check("log_out_held", int'(log_out), seen_log);
                    check("zero_err_held", int'(zero_err), seen_err);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input int x);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            in_valid    = 1'b1;
            standard_in = x[M-1:0];
            e           = model(x);
            e.acc       = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid    = 1'b0;
            standard_in = M'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int n;
        int rst_x;
        int rst_pre;
        build_model();
`ifdef BCH_LOG_BIDIR_SEARCH_EN
        rst_x = 'b1011;   // alpha^7: still searching at the reset point
`else
        rst_x = 'b1001;   // alpha^14
`endif
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_log_out", int'(log_out), 0);
        check("rst_zero_err", int'(zero_err), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        // directed values
        send('b0001);
        send('b0011);
        send('b1001);
        send('b0000);
        wait_drain();

        // consumer stalls; in_valid while busy must be ignored
        hold_ready = 1'b1;
        send('b0010);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid    = 1'b1;
            standard_in = M'($urandom);
            @(negedge clk);
            check("busy_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        hold_ready = 1'b0;
        wait_drain();

        // reset during a search discards the result
        send(rst_x);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_mid_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", int'(in_ready), 1);
        rst_pre = n_err;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) check("rst_no_pulse", 1, 0);
        end
        check("rst_quiet_window", n_err - rst_pre, 0);
        send('b0100);
        wait_drain();

        // sweep of all nonzero elements
        for (int x = 1; x < NEL; x++) send(x);
        wait_drain();

        // random operands with random gaps
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(int'($urandom_range(0, NEL - 1)));
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
